// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus between the fetch unit (master) and instruction memory (slave).
// Handshake: ImemReq/ImemAddr come from the master; ImemData is taken in the same cycle ImemAck is seen while ImemReq=1.
interface instr_fetch_unit_if;
    logic [31:0] ImemAddr;
    logic        ImemReq;
    logic        ImemAck;
    logic [31:0] ImemData;

    modport master (
        output ImemAddr,
        output ImemReq,
        input  ImemAck,
        input  ImemData
    );

    modport slave (
        input  ImemAddr,
        input  ImemReq,
        output ImemAck,
        output ImemData
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS32 fetch front end: owns the PC, fetches over a req/ack bus, splits instruction fields, computes NextPC.
// Optional issued-instruction counter enabled by defining IFU_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  imem,
    output logic [WORD_LEN-1:0] Instr,
    output logic [5:0]          OpCode,
    output logic [4:0]          Rs,
    output logic [4:0]          Rt,
    output logic [4:0]          Rd,
    output logic [5:0]          Funct,
    output logic [15:0]         Imm16,
    output logic                InstrValid,
    output logic [WORD_LEN-1:0] PC,
    output logic [WORD_LEN-1:0] PCPlus4,
    input  logic                Jump,
    input  logic                Branch,
    input  logic                Zero,
    input  logic                Stall,
    output logic [WORD_LEN-1:0] FetchCount,
    output logic                dbg_state_o
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_LEN-1:0] pc_q, pc_d;
    logic [WORD_LEN-1:0] instr_q, instr_d;
    logic [WORD_LEN-1:0] next_pc;
    logic [WORD_LEN-1:0] br_off;
    logic                req;
    logic                valid;

    assign PCPlus4 = pc_q + 32'd4;
    assign br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Jump outranks Branch; a branch is only taken when the ALU reports Zero.
    always_comb begin
        next_pc = PCPlus4;
        if (Jump) begin
            next_pc = {PCPlus4[31:28], instr_q[25:0], 2'b00};
        end else if (Branch && Zero) begin
            next_pc = PCPlus4 + br_off;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        req     = 1'b0;
        valid   = 1'b0;
        case (state_q)
            S_FETCH: begin
                // The request is masked by rst so an in-flight access is dropped the moment reset rises.
                req = !rst;
                if (req && imem.ImemAck) begin
                    instr_d = imem.ImemData;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                valid = 1'b1;
                if (!Stall) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem.ImemReq  = req;
    assign imem.ImemAddr = pc_q;
    assign InstrValid    = valid;
    assign PC            = pc_q;
    assign Instr         = instr_q;
    assign OpCode        = instr_q[31:26];
    assign Rs            = instr_q[25:21];
    assign Rt            = instr_q[20:16];
    assign Rd            = instr_q[15:11];
    assign Funct         = instr_q[5:0];
    assign Imm16         = instr_q[15:0];
    assign dbg_state_o   = state_q;

`ifdef IFU_PERF_CNT_EN
    logic                issue_go;
    logic [WORD_LEN-1:0] cnt_q;

    assign issue_go = (state_q == S_ISSUE) && !Stall;

    // Saturating so a long run never wraps back to a misleadingly small count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (issue_go && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign FetchCount = cnt_q;
`else
    assign FetchCount = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios then randomized fetch/issue traffic against a PC model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] Instr;
    logic [5:0]  OpCode;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [5:0]  Funct;
    logic [15:0] Imm16;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Jump;
    logic        Branch;
    logic        Zero;
    logic        Stall;
    logic [31:0] FetchCount;
    logic        dbg_state;

    instr_fetch_unit_if imem ();

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .WORD_LEN (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem.master),
        .Instr       (Instr),
        .OpCode      (OpCode),
        .Rs          (Rs),
        .Rt          (Rt),
        .Rd          (Rd),
        .Funct       (Funct),
        .Imm16       (Imm16),
        .InstrValid  (InstrValid),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .Jump        (Jump),
        .Branch      (Branch),
        .Zero        (Zero),
        .Stall       (Stall),
        .FetchCount  (FetchCount),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state and reference model
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pc_m;
    logic [31:0] cnt_m;
    logic [31:0] last_instr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Next address from the architectural rules, using signed arithmetic on the offset.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic j, input logic b, input logic z);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        if (j) return (seq & 32'hF000_0000) + ((ins & 32'h03FF_FFFF) * 32'd4);
        if (b && z) begin
            off = int'($signed(ins[15:0])) * 4;
            return seq + 32'(off);
        end
        return seq;
    endfunction

    function automatic logic [31:0] exp_count();
`ifdef IFU_PERF_CNT_EN
        return cnt_m;
`else
        return 32'h0;
`endif
    endfunction

    task automatic scramble_ctrl();
        Jump   = 1'($urandom_range(0, 1));
        Branch = 1'($urandom_range(0, 1));
        Zero   = 1'($urandom_range(0, 1));
        Stall  = 1'($urandom_range(0, 1));
    endtask

    // Driver: memory answers after 'delay' wait cycles, then the issued instruction is checked.
    task automatic do_fetch(input int delay, input logic [31:0] data);
        logic [31:0] e;
        check("fetch_req", 32'(imem.ImemReq), 32'd1);
        check("fetch_addr", imem.ImemAddr, pc_m);
        check("fetch_pc", PC, pc_m);
        check("fetch_valid", 32'(InstrValid), 32'd0);
        check("fetch_count", FetchCount, exp_count());
        for (int i = 0; i < delay; i++) begin
            imem.ImemAck = 1'b0;
            scramble_ctrl();
            @(negedge clk);
            check("wait_req", 32'(imem.ImemReq), 32'd1);
            check("wait_addr", imem.ImemAddr, pc_m);
            check("wait_valid", 32'(InstrValid), 32'd0);
        end
        imem.ImemAck  = 1'b1;
        imem.ImemData = data;
        exp_q.push_back(data);
        @(negedge clk);
        imem.ImemAck  = 1'b0;
        imem.ImemData = $urandom;
        e = exp_q.pop_front();
        last_instr = e;
        check("issue_valid", 32'(InstrValid), 32'd1);
        check("issue_req", 32'(imem.ImemReq), 32'd0);
        check("issue_instr", Instr, e);
        check("issue_opcode", 32'(OpCode), 32'(e[31:26]));
        check("issue_rs", 32'(Rs), 32'(e[25:21]));
        check("issue_rt", 32'(Rt), 32'(e[20:16]));
        check("issue_rd", 32'(Rd), 32'(e[15:11]));
        check("issue_funct", 32'(Funct), 32'(e[5:0]));
        check("issue_imm16", 32'(Imm16), 32'(e[15:0]));
        check("issue_pc", PC, pc_m);
        check("issue_pcplus4", PCPlus4, pc_m + 32'd4);
    endtask

    task automatic do_issue(input int stall_n, input logic j, input logic b, input logic z);
        for (int i = 0; i < stall_n; i++) begin
            Stall = 1'b1;
            imem.ImemAck = 1'($urandom_range(0, 1));
            Jump   = 1'($urandom_range(0, 1));
            Branch = 1'($urandom_range(0, 1));
            Zero   = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("stall_valid", 32'(InstrValid), 32'd1);
            check("stall_req", 32'(imem.ImemReq), 32'd0);
            check("stall_instr", Instr, last_instr);
            check("stall_pc", PC, pc_m);
            check("stall_count", FetchCount, exp_count());
        end
        Stall        = 1'b0;
        imem.ImemAck = 1'b0;
        Jump         = j;
        Branch       = b;
        Zero         = z;
        pc_m  = model_next(pc_m, last_instr, j, b, z);
        cnt_m = cnt_m + 32'd1;
        @(negedge clk);
        scramble_ctrl();
    endtask

    task automatic seq_step(input logic [31:0] data);
        do_fetch(0, data);
        do_issue(0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        imem.ImemAck  = 1'b0;
        imem.ImemData = 32'h0;
        Jump   = 1'b0;
        Branch = 1'b0;
        Zero   = 1'b0;
        Stall  = 1'b0;
        pc_m   = RST_PC;
        cnt_m  = 32'h0;
        last_instr = 32'h0;

        #2;
        check("rst_req", 32'(imem.ImemReq), 32'd0);
        check("rst_pc", PC, RST_PC);
        check("rst_instr", Instr, 32'h0);
        check("rst_valid", 32'(InstrValid), 32'd0);
        check("rst_count", FetchCount, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_req", 32'(imem.ImemReq), 32'd1);
        @(negedge clk);

        // Sequential add stream at 0,4,8 with zero-wait ack
        do_fetch(0, 32'h0000_0020);
        check("add_opcode", 32'(OpCode), 32'h0);
        check("add_funct", 32'(Funct), 32'h20);
        do_issue(0, 1'b0, 1'b0, 1'b0);
        do_fetch(3, 32'h0000_0020);
        do_issue(0, 1'b0, 1'b0, 1'b0);

        // BEQ at 8, offset -2 words: taken goes to 4, not taken to C
        do_fetch(0, 32'h1000_FFFE);
        do_issue(0, 1'b0, 1'b1, 1'b1);
        check("beq_taken", pc_m, 32'h0000_0004);
        seq_step(32'h0000_0020);
        do_fetch(0, 32'h1000_FFFE);
        do_issue(0, 1'b0, 1'b1, 1'b0);
        check("beq_not_taken", pc_m, 32'h0000_000C);

        // Branch backwards past zero to the top word, then wrap sequentially
        do_fetch(0, 32'h1000_FFFB);
        do_issue(0, 1'b0, 1'b1, 1'b1);
        do_fetch(1, 32'h0000_0020);
        check("top_pc", PC, 32'hFFFF_FFFC);
        do_issue(0, 1'b0, 1'b0, 1'b0);
        do_fetch(0, 32'h0BFF_FFFF);
        check("wrap_pc", PC, 32'h0000_0000);

        // Jump to 0x0FFFFFFC, walk into the 0x1 region, then J with Branch also set
        do_issue(0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) seq_step($urandom);
        do_fetch(0, 32'h0800_0040);
        check("j_pc", PC, 32'h1000_0010);
        do_issue(0, 1'b1, 1'b1, 1'b1);
        check("j_target", pc_m, 32'h1000_0100);

        // Four-cycle stall then resume at PC+4
        do_fetch(2, $urandom);
        do_issue(4, 1'b0, 1'b0, 1'b0);
        check("stall_resume", pc_m, 32'h1000_0104);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            do_fetch($urandom_range(0, 3), $urandom);
            do_issue($urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset while waiting for an ack
        imem.ImemAck = 1'b0;
        @(negedge clk);
        check("pre_rst_req", 32'(imem.ImemReq), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(imem.ImemReq), 32'd0);
        check("midrst_pc", PC, RST_PC);
        check("midrst_valid", 32'(InstrValid), 32'd0);
        check("midrst_instr", Instr, 32'h0);
        check("midrst_count", FetchCount, 32'h0);
        pc_m  = RST_PC;
        cnt_m = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_fetch(1, 32'h0000_0020);
        do_issue(0, 1'b0, 1'b0, 1'b0);
        do_fetch(0, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front end of the single-issue MIPS32 core. It owns the PC and fetches words from instruction memory over a req/ack handshake. It presents the instruction fields (OpCode, Funct, register indices, immediate) to the main control and ALU control decoders. It takes back the decoder's Jump/Branch decision plus the ALU Zero flag and computes the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
WORD_LEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  asynchronous reset, active high
ImemAddr  out  32  fetch address; always equals PC
ImemReq  out  1  fetch request; high only in FETCH state
ImemAck  in  1  memory has ImemData valid this cycle
ImemData  in  32  instruction word; sampled when ImemReq&ImemAck
Instr  out  32  registered instruction word
OpCode  out  6  Instr[31:26]
Rs  out  5  Instr[25:21]
Rt  out  5  Instr[20:16]
Rd  out  5  Instr[15:11]
Funct  out  6  Instr[5:0]
Imm16  out  16  Instr[15:0]
InstrValid  out  1  Instr and fields valid for decode/execute
PC  out  32  address of the instruction in Instr (ISSUE) or being fetched (FETCH)
PCPlus4  out  32  PC+4, combinational, wraps mod 2^32
Jump  in  1  from main control; sampled in ISSUE
Branch  in  1  from main control; sampled in ISSUE
Zero  in  1  ALU zero flag; sampled in ISSUE
Stall  in  1  hold the current instruction in ISSUE
FetchCount  out  32  issued-instruction counter (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state=FETCH, PC=RESET_PC, Instr=0, InstrValid=0, FetchCount=0. ImemReq=0 while rst is high. ImemReq rises in the first cycle after deassertion.
- State FETCH:
  - ImemReq=1, InstrValid=0.
  - ImemAddr/PC held stable until ack.
  - On ImemReq&ImemAck (a same-cycle ack is legal): Instr<=ImemData, state<=ISSUE.
  - No ack: remain in FETCH indefinitely.
- State ISSUE:
  - ImemReq=0, InstrValid=1.
  - ImemAck is ignored in this state.
  - Stall=1: hold everything; InstrValid stays 1, Instr/PC unchanged.
  - Stall=0: PC<=NextPC, state<=FETCH, InstrValid falls the next cycle.
- NextPC priority:
  - Jump=1: {PCPlus4[31:28], Instr[25:0], 2'b00}. Jump wins over Branch.
  - else Branch&Zero: PCPlus4 + ({{14{Imm16[15]}}, Imm16, 2'b00}), mod 2^32.
  - else: PCPlus4.
- Latency:
  - Ack in cycle n gives InstrValid=1 in cycle n+1.
  - Minimum 2 cycles per instruction (zero-wait ack, no stall).
- PC wrap: PC=32'hFFFF_FFFC, sequential, gives next PC 32'h0000_0000. No error is raised.
- Reset mid-fetch: request dropped immediately. The memory must discard the outstanding access. A late ack after reset is only honoured when ImemReq=1.
- X safety: Jump/Branch/Zero/Stall are don't-care outside ISSUE.

Optional Feature:
Macro IFU_PERF_CNT_EN.
- Defined: FetchCount increments by 1 on each ISSUE->FETCH transition (Stall=0). It saturates at 32'hFFFF_FFFF and is cleared by rst.
- Undefined: FetchCount is tied to 32'h0 and no counter logic is synthesised.

Test Plan:
- Reset, zero-wait ack, memory returns 32'h0000_0020 (add) at 0 -> ImemAddr sequence 0,4,8. InstrValid pulses every 2nd cycle. OpCode=0, Funct=6'h20.
- Ack delayed 3 cycles at PC=4 -> ImemReq/ImemAddr=4 held 3 cycles. InstrValid=1 exactly one cycle after ack.
- BEQ at PC=8, Imm16=16'hFFFE, Branch=1, Zero=1 -> next fetch at 32'h0000_0004. Same with Zero=0 -> next fetch at 32'h0000_000C.
- J at PC=32'h1000_0010, target field 26'h000_0040, Jump=1 and Branch=1 -> next fetch at 32'h1000_0100.
- Stall=1 for 4 ISSUE cycles -> Instr/PC/InstrValid constant, ImemReq=0. Stall=0 -> fetch resumes at PC+4. With IFU_PERF_CNT_EN, FetchCount increments once.
- RESET_PC=32'hFFFF_FFFC, sequential fetch -> second fetch address is 32'h0. Assert rst during FETCH wait -> ImemReq=0 immediately, PC=RESET_PC, InstrValid=0.
